// File: rtl/pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pattern_sequencer
// Brief    : Plays a programmable address range from a synchronous-ack pattern
//            memory onto a parallel output bus. Supports loop, one-shot and
//            ping-pong modes with a per-step dwell and enable-gated holding.
//            Ping-pong direction logic exists only when PATTERN_SEQ_PINGPONG_EN
//            is defined; otherwise mode 2'b10 plays as loop.
// Revision : 1.0  initial release
// ============================================================================
module pattern_sequencer #(
    parameter int WORD_SIZE    = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int DWELL_BITS   = 8
) (
    input  logic                    slow_clock,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic                    i_enable,
    input  logic [1:0]              i_mode,
    input  logic [ADDRESS_SIZE-1:0] i_start_addr,
    input  logic [ADDRESS_SIZE-1:0] i_end_addr,
    input  logic [DWELL_BITS-1:0]   i_dwell,
    input  logic [WORD_SIZE-1:0]    i_r_data,
    input  logic                    i_r_ready,
    output logic                    o_r_en,
    output logic [ADDRESS_SIZE-1:0] o_r_addr,
    output logic [WORD_SIZE-1:0]    o_sequence,
    output logic                    o_step_strobe,
    output logic                    o_busy,
    output logic                    o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]              c_MODE_ONESHOT = 2'b01;
    localparam logic [ADDRESS_SIZE-1:0] c_ADDR_ONE     = {{(ADDRESS_SIZE-1){1'b0}}, 1'b1};
    localparam logic [DWELL_BITS-1:0]   c_DWELL_ONE    = {{(DWELL_BITS-1){1'b0}}, 1'b1};

    state_t                  r_state;
    logic [1:0]              r_mode;
    logic [ADDRESS_SIZE-1:0] r_start_addr;
    logic [ADDRESS_SIZE-1:0] r_end_addr;
    logic [DWELL_BITS-1:0]   r_dwell;
    logic [DWELL_BITS-1:0]   r_dwell_cnt;
    logic                    r_ack_d;

    logic                    w_ack;
    logic                    w_start_ok;
    logic                    w_hold_term;
    logic                    w_finish;
    logic [ADDRESS_SIZE-1:0] w_loop_next;
    logic [ADDRESS_SIZE-1:0] w_next_addr;

    assign w_ack       = (r_state == S_FETCH) && o_r_en && i_r_ready;
    assign w_start_ok  = i_start && !i_stop && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_hold_term = (r_state == S_HOLD) && i_enable && (r_dwell_cnt == r_dwell);
    assign w_finish    = (r_mode == c_MODE_ONESHOT) && (o_r_addr == r_end_addr);
    assign w_loop_next = (o_r_addr == r_end_addr) ? r_start_addr : (o_r_addr + c_ADDR_ONE);

`ifdef PATTERN_SEQ_PINGPONG_EN
    localparam logic [1:0] c_MODE_PINGPONG = 2'b10;

    logic r_dir_down;
    logic w_next_dir_down;

    // End words are visited once per turn: the reversal step moves straight
    // to the neighbour instead of re-fetching the end address.
    always_comb begin
        w_next_dir_down = r_dir_down;
        w_next_addr     = w_loop_next;
        if (r_mode == c_MODE_PINGPONG) begin
            if (r_start_addr == r_end_addr) begin
                w_next_addr = r_start_addr;
            end else if (!r_dir_down) begin
                if (o_r_addr == r_end_addr) begin
                    w_next_dir_down = 1'b1;
                    w_next_addr     = o_r_addr - c_ADDR_ONE;
                end else begin
                    w_next_addr = o_r_addr + c_ADDR_ONE;
                end
            end else begin
                if (o_r_addr == r_start_addr) begin
                    w_next_dir_down = 1'b0;
                    w_next_addr     = o_r_addr + c_ADDR_ONE;
                end else begin
                    w_next_addr = o_r_addr - c_ADDR_ONE;
                end
            end
        end
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            r_dir_down <= 1'b0;
        end else if (w_start_ok) begin
            r_dir_down <= 1'b0;
        end else if (w_hold_term && !i_stop) begin
            r_dir_down <= w_next_dir_down;
        end
    end
`else
    always_comb begin
        w_next_addr = w_loop_next;
    end
`endif

    // step_strobe trails the sequence update by one cycle; an ack discarded
    // by stop never produces a strobe.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            r_ack_d       <= 1'b0;
            o_step_strobe <= 1'b0;
        end else begin
            r_ack_d       <= w_ack && !i_stop;
            o_step_strobe <= r_ack_d;
        end
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mode       <= 2'b00;
            r_start_addr <= '0;
            r_end_addr   <= '0;
            r_dwell      <= '0;
            r_dwell_cnt  <= '0;
            o_r_en       <= 1'b0;
            o_r_addr     <= '0;
            o_sequence   <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else if (i_stop) begin
            r_state <= S_IDLE;
            o_r_en  <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_mode       <= i_mode;
                        r_start_addr <= i_start_addr;
                        r_end_addr   <= i_end_addr;
                        r_dwell      <= i_dwell;
                        r_state      <= S_FETCH;
                        o_r_en       <= 1'b1;
                        o_r_addr     <= i_start_addr;
                        o_busy       <= 1'b1;
                        o_done       <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (w_ack) begin
                        o_sequence  <= i_r_data;
                        o_r_en      <= 1'b0;
                        r_dwell_cnt <= '0;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_hold_term) begin
                        if (w_finish) begin
                            r_state <= S_DONE;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                        end else begin
                            r_state  <= S_FETCH;
                            o_r_en   <= 1'b1;
                            o_r_addr <= w_next_addr;
                        end
                    end else if (i_enable) begin
                        r_dwell_cnt <= r_dwell_cnt + c_DWELL_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_r_en  <= 1'b0;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
